// File: rtl/instr_fetch_arbiter.sv
// ---------------------------------------------------------------------------
// instr_fetch_arbiter
//
// Shares the single read port of the instruction memory between four core
// fetch units. One fetch is issued per cycle and the path is fully pipelined:
//   edge t   : arbitration, gnt pulse, mem_addr registered
//   edge t+1 : memory samples mem_addr (registered read data)
//   edge t+2 : mem_instr captured into instr_out, one-hot valid pulse
// Each core has at most one fetch outstanding; a core with a fetch in flight
// is masked from arbitration until its valid pulse has been issued.
//
// Build option:
//   FETCH_ARB_FIXED_PRIO_EN  defined   -> fixed priority core1 > ... > core4
//                            undefined -> round-robin (default)
//   Latency, busy masking and port timing are the same in both builds.
//
// Ports:
//   clk        in   system clock, all state on posedge
//   rst        in   synchronous active-high reset
//   req[3:0]   in   fetch request per core (bit0 = core1 ... bit3 = core4)
//   addr1..4   in   per-core fetch address
//   mem_addr   out  registered address to the memory read port
//   mem_instr  in   memory read data, valid one cycle after mem_addr sampled
//   gnt[3:0]   out  one-hot one-cycle pulse, request accepted
//   instr_out  out  returned instruction, shared by all cores
//   valid[3:0] out  one-hot one-cycle pulse, instr_out belongs to this core
// ---------------------------------------------------------------------------
module instr_fetch_arbiter #(
    parameter int ADDR_W  = 12,
    parameter int INSTR_W = 18
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [3:0]         req,
    input  logic [ADDR_W-1:0]  addr1,
    input  logic [ADDR_W-1:0]  addr2,
    input  logic [ADDR_W-1:0]  addr3,
    input  logic [ADDR_W-1:0]  addr4,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic [INSTR_W-1:0] mem_instr,
    output logic [3:0]         gnt,
    output logic [INSTR_W-1:0] instr_out,
    output logic [3:0]         valid
);

    // Decode a 2-bit core index to its one-hot request/grant bit.
    function automatic logic [3:0] onehot4(input logic [1:0] id);
        logic [3:0] oh;
        case (id)
            2'd0:    oh = 4'b0001;
            2'd1:    oh = 4'b0010;
            2'd2:    oh = 4'b0100;
            2'd3:    oh = 4'b1000;
            default: oh = 4'b0000;
        endcase
        return oh;
    endfunction

    logic [3:0]         busy_r;
    logic [3:0]         busy_nxt_s;
    logic [3:0]         elig_s;
    logic               win_vld_s;
    logic [1:0]         win_id_s;
    logic [3:0]         win_oh_s;
    logic [ADDR_W-1:0]  win_addr_s;
    logic [3:0]         ret_oh_s;

    logic               s1_vld_r;
    logic [1:0]         s1_id_r;
    logic               s2_vld_r;
    logic [1:0]         s2_id_r;

    logic [3:0]         gnt_r;
    logic [ADDR_W-1:0]  mem_addr_r;
    logic [INSTR_W-1:0] instr_r;
    logic [3:0]         valid_r;

    // A core with a fetch in flight may not be granted again.
    assign elig_s = req & ~busy_r;

`ifdef FETCH_ARB_FIXED_PRIO_EN

    // Fixed priority winner select: lowest index wins.
    always_comb begin
        win_vld_s = 1'b0;
        win_id_s  = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (elig_s[k]) begin
                win_vld_s = 1'b1;
                win_id_s  = 2'(k);
            end else begin
                win_vld_s = win_vld_s;
            end
        end
    end

`else

    logic [1:0] rr_last_r;
    logic [1:0] cand_s;

    // Round-robin winner select: first eligible core after the last winner.
    always_comb begin
        win_vld_s = 1'b0;
        win_id_s  = 2'd0;
        cand_s    = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            cand_s = rr_last_r + 2'(k);
            if (!win_vld_s && elig_s[cand_s]) begin
                win_vld_s = 1'b1;
                win_id_s  = cand_s;
            end else begin
                win_vld_s = win_vld_s;
            end
        end
    end

    // Round-robin pointer: only moves when something is granted.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_last_r <= 2'd3;
        end else if (win_vld_s) begin
            rr_last_r <= win_id_s;
        end else begin
            rr_last_r <= rr_last_r;
        end
    end

`endif

    // Winner address mux.
    always_comb begin
        win_addr_s = {ADDR_W{1'b0}};
        case (win_id_s)
            2'd0:    win_addr_s = addr1;
            2'd1:    win_addr_s = addr2;
            2'd2:    win_addr_s = addr3;
            2'd3:    win_addr_s = addr4;
            default: win_addr_s = {ADDR_W{1'b0}};
        endcase
    end

    // Busy update: set on grant, clear on return. The mask guarantees the
    // two never hit the same core in one cycle.
    always_comb begin
        win_oh_s   = 4'b0000;
        ret_oh_s   = 4'b0000;
        busy_nxt_s = busy_r;
        if (win_vld_s) begin
            win_oh_s = onehot4(win_id_s);
        end else begin
            win_oh_s = 4'b0000;
        end
        if (s2_vld_r) begin
            ret_oh_s = onehot4(s2_id_r);
        end else begin
            ret_oh_s = 4'b0000;
        end
        busy_nxt_s = (busy_r & ~ret_oh_s) | win_oh_s;
    end

    // Outstanding-fetch mask register.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r <= 4'b0000;
        end else begin
            busy_r <= busy_nxt_s;
        end
    end

    // Issue stage: grant pulse, memory address and first pipeline slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_r      <= 4'b0000;
            mem_addr_r <= {ADDR_W{1'b0}};
            s1_vld_r   <= 1'b0;
            s1_id_r    <= 2'd0;
        end else if (win_vld_s) begin
            gnt_r      <= win_oh_s;
            mem_addr_r <= win_addr_s;
            s1_vld_r   <= 1'b1;
            s1_id_r    <= win_id_s;
        end else begin
            gnt_r      <= 4'b0000;
            mem_addr_r <= mem_addr_r;
            s1_vld_r   <= 1'b0;
            s1_id_r    <= s1_id_r;
        end
    end

    // Second pipeline slot, aligned with the memory's registered read.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_vld_r <= 1'b0;
            s2_id_r  <= 2'd0;
        end else begin
            s2_vld_r <= s1_vld_r;
            s2_id_r  <= s1_id_r;
        end
    end

    // Return stage: capture read data and pulse the owner's valid bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            instr_r <= {INSTR_W{1'b0}};
            valid_r <= 4'b0000;
        end else if (s2_vld_r) begin
            instr_r <= mem_instr;
            valid_r <= onehot4(s2_id_r);
        end else begin
            instr_r <= instr_r;
            valid_r <= 4'b0000;
        end
    end

    assign gnt       = gnt_r;
    assign mem_addr  = mem_addr_r;
    assign instr_out = instr_r;
    assign valid     = valid_r;

endmodule
